// File: rtl/obuf_pkg.sv
// Shared types and parameter helpers for the OBUF load sequencer.
package obuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_row_w(input int num_banks, input int data_width);
    return num_banks * data_width;
  endfunction

  function automatic int calc_ratio(input int ddr_bw, input int num_banks, input int data_width);
    return ddr_bw / calc_row_w(num_banks, data_width);
  endfunction

  // RATIO is legal only when a beat splits into a whole number (>=1) of rows.
  function automatic bit ratio_ok(input int ddr_bw, input int num_banks, input int data_width);
    int rw;
    rw = calc_row_w(num_banks, data_width);
    return (rw > 0) && (ddr_bw >= rw) && ((ddr_bw % rw) == 0);
  endfunction

  function automatic int calc_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/obuf_row_mux.sv
// RATIO-to-1 selector picking one bank-row out of the held DDR beat.
module obuf_row_mux
  import obuf_pkg::*;
#(
  parameter int RATIO = 2,
  parameter int ROW_W = 256,
  parameter int CNT_W = 1
) (
  input  logic [RATIO*ROW_W-1:0] hold,
  input  logic [CNT_W-1:0]       sel,
  output logic [ROW_W-1:0]       row
);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    row = '0;
    for (int r = 0; r < RATIO; r++) begin
      if (sel == CNT_W'(r)) row = hold[r*ROW_W +: ROW_W];
    end
  end

endmodule

// File: rtl/obuf_ld_sequencer.sv
// Splits DDR read beats into OBUF bank-rows and writes them one row per cycle.
// Optional starvation counter output stall_cycles when OBUF_LD_STALL_CNT_EN is defined.
module obuf_ld_sequencer
  import obuf_pkg::*;
#(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int BEAT_CNT_W    = 16,
  localparam int ROW_W        = calc_row_w(NUM_BANKS, DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [BEAT_CNT_W-1:0]    num_beats,
  output logic                     busy,
  output logic                     done,
  input  logic                     ddr_valid,
  input  logic [DDR_BANDWIDTH-1:0] ddr_data,
  output logic                     ddr_ready,
  output logic                     obuf_wr_en,
  output logic [ADDR_WIDTH-1:0]    obuf_wr_addr,
  output logic [ROW_W-1:0]         obuf_wr_data
`ifdef OBUF_LD_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int RATIO = calc_ratio(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH);
  localparam int CNT_W = calc_cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(RATIO - 1);

  if (!ratio_ok(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH)) begin : g_bad_ratio
    $error("DDR_BANDWIDTH must be a whole multiple (>=1) of NUM_BANKS*DATA_WIDTH");
  end

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BEAT_CNT_W-1:0]   beats_left;
  logic [DDR_BANDWIDTH-1:0] hold_q;
  logic                    hold_vld;
  logic [CNT_W-1:0]        row_cnt;
  logic                    last_row;
  logic                    accept;

  assign last_row = (row_cnt == LAST_ROW);
  assign accept   = ddr_valid && ddr_ready;

  // ddr_ready decodes registered state only, never ddr_valid.
  always_comb begin
    state_d   = state;
    busy      = 1'b0;
    done      = 1'b0;
    ddr_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_d = (num_beats == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        ddr_ready = (beats_left != '0) && (!hold_vld || last_row);
        if (hold_vld && last_row && (beats_left == '0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // NOTE: hold_q is reset too, so obuf_wr_data reads 0 after reset instead of stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      beats_left <= '0;
      hold_q     <= '0;
      hold_vld   <= 1'b0;
      row_cnt    <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr_q     <= base_addr;
        beats_left <= num_beats;
      end
      if (hold_vld) addr_q <= addr_q + ADDR_WIDTH'(1);
      if (accept) begin
        hold_q     <= ddr_data;
        hold_vld   <= 1'b1;
        row_cnt    <= '0;
        beats_left <= beats_left - BEAT_CNT_W'(1);
      end else if (hold_vld) begin
        if (last_row) begin
          hold_vld <= 1'b0;
          row_cnt  <= '0;
        end else begin
          row_cnt <= row_cnt + CNT_W'(1);
        end
      end
    end
  end

  obuf_row_mux #(
    .RATIO (RATIO),
    .ROW_W (ROW_W),
    .CNT_W (CNT_W)
  ) u_row_mux (
    .hold (hold_q),
    .sel  (row_cnt),
    .row  (obuf_wr_data)
  );

  assign obuf_wr_en   = hold_vld;
  assign obuf_wr_addr = addr_q;

`ifdef OBUF_LD_STALL_CNT_EN
  // Counts RUN cycles starved of input; cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cycles <= '0;
    end else if (state == ST_RUN && !hold_vld && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
